// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
// Holds the FSM state encoding and the last-grant constants used by round-robin.
// No logic lives here; types and constants only.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_D  = 2'd2,
    RESP     = 2'd3
  } arb_state_t;

  // Which requester owned the most recently completed memory transaction.
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Watchdog: counts consecutive cycles mem_req is high without mem_ack.
// Latency: timeout is combinational in the MAX_WAIT-th unanswered mem_req cycle.
// Backpressure: none; the counter clears whenever mem_req drops or mem_ack arrives.
module mem_arb_watchdog #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req,
  input  logic mem_ack,
  output logic timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt;

  // Count unanswered request cycles; restart on any ack or idle cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (mem_req && !mem_ack) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // cnt holds the number of earlier unanswered cycles, so fire on MAX_WAIT-1.
  assign timeout = mem_req && !mem_ack && (cnt == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Latency: 2 cycles minimum (grant edge, ack edge), ready pulses in the RESP cycle.
// Backpressure: holds mem_* until mem_ack; stall holds the core. Optional MEM_ARB_TIMEOUT_EN watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              err
);

  arb_state_t state;
  grant_t     last_grant;
  logic       timeout;
  logic       done;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .MAX_WAIT(MAX_WAIT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .mem_req(mem_req),
    .mem_ack(mem_ack),
    .timeout(timeout)
  );

  // Sticky error: set by any watchdog expiry, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // A grant finishes on a real ack or, with the watchdog, on expiry (ack has priority).
  assign done = mem_ack || timeout;

  // Arbitration FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= GNT_D;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          // Fetch wins when alone, or on a tie when data went last.
          if (if_req && (!d_req || last_grant == GNT_D)) begin
            state     <= GRANT_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end else if (d_req) begin
            state     <= GRANT_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end
        end
        GRANT_IF: begin
          if (done) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            last_grant <= GNT_IF;
            if_ready   <= 1'b1;
            if_rdata   <= mem_ack ? mem_rdata : '1;
          end
        end
        GRANT_D: begin
          if (done) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            last_grant <= GNT_D;
            d_ready    <= 1'b1;
            if (!mem_ack) begin
              d_rdata <= '1;
            end else if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic.
// Inputs change 1 time unit after the rising edge; outputs are sampled a further unit later.
// Timeout scenario is compiled only with MEM_ARB_TIMEOUT_EN defined.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          stall;
  logic          err;

  int checks = 0;
  int errors = 0;

  // Reference model state: who was served last and what each rdata register holds.
  bit            last_was_d = 1'b1;
  logic [DW-1:0] if_rdata_exp = '0;
  logic [DW-1:0] d_rdata_exp = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1, "global timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Advance until mem_req is seen; cycles = number of edges taken.
  task automatic wait_mem_req(input int budget, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      cycles++;
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic model_reset;
    last_was_d   = 1'b1;
    if_rdata_exp = '0;
    d_rdata_exp  = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_req, mem_we, if_ready, d_ready, err, stall} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got req=%b we=%b ifr=%b dr=%b err=%b stall=%b, want all 0",
               mem_req, mem_we, if_ready, d_ready, err, stall);
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h ifrd=%h drd=%h, want 0",
               mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    reset = 1'b1;
    model_reset();
    tick();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got mem_req=%b, want 0", mem_req);
    end
  endtask

  task automatic test_tie;
    int cyc;
    bit ok;
    if_addr = 32'h0000_0040;
    d_addr  = 32'h0000_0300;
    d_we    = 1'b0;
    if_req  = 1'b1;
    d_req   = 1'b1;
    wait_mem_req(4, cyc, ok);
    checks++;
    if (!ok || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL tie_first: got ok=%b addr=%h we=%b, want fetch addr=00000040 we=0", ok, mem_addr, mem_we);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h1111_0000;
    tick();
    mem_ack = 1'b0;
    if_rdata_exp = 32'h1111_0000;
    last_was_d = 1'b0;
    checks++;
    if ({if_ready, d_ready, mem_req} !== 3'b100 || if_rdata !== if_rdata_exp) begin
      errors++;
      $display("FAIL tie_first_resp: got ifr=%b dr=%b req=%b ifrd=%h, want 1 0 0 %h",
               if_ready, d_ready, mem_req, if_rdata, if_rdata_exp);
    end
    if_req = 1'b0;
    wait_mem_req(4, cyc, ok);
    checks++;
    if (!ok || mem_addr !== 32'h300 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL tie_second: got ok=%b addr=%h we=%b, want data addr=00000300 we=0", ok, mem_addr, mem_we);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h2222_0000;
    tick();
    mem_ack = 1'b0;
    d_rdata_exp = 32'h2222_0000;
    last_was_d = 1'b1;
    checks++;
    if ({if_ready, d_ready} !== 2'b01 || d_rdata !== d_rdata_exp) begin
      errors++;
      $display("FAIL tie_second_resp: got ifr=%b dr=%b drd=%h, want 0 1 %h", if_ready, d_ready, d_rdata, d_rdata_exp);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_single_read;
    tick();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0100;
    #1;
    checks++;
    if (stall !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL read_cycle0: got stall=%b req=%b, want stall=1 req=0", stall, mem_req);
    end
    tick();
    checks++;
    if ({mem_req, mem_we, stall} !== 3'b101 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL read_cycle1: got req=%b we=%b stall=%b addr=%h, want 1 0 1 00000100",
               mem_req, mem_we, stall, mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ack = 1'b0;
    d_rdata_exp = 32'hCAFE_0001;
    last_was_d = 1'b1;
    checks++;
    if ({d_ready, if_ready, mem_req, stall} !== 4'b1000 || d_rdata !== d_rdata_exp) begin
      errors++;
      $display("FAIL read_cycle2: got dr=%b ifr=%b req=%b stall=%b drd=%h, want 1 0 0 0 cafe0001",
               d_ready, if_ready, mem_req, stall, d_rdata);
    end
    d_req = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (d_ready !== 1'b0 || d_rdata !== d_rdata_exp) begin
      errors++;
      $display("FAIL read_hold: got dr=%b drd=%h, want 0 %h", d_ready, d_rdata, d_rdata_exp);
    end
  endtask

  task automatic test_write_delay;
    int cyc;
    bit ok;
    int pulses;
    pulses  = 0;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0200;
    d_wdata = 32'h1234_5678;
    d_req   = 1'b1;
    wait_mem_req(4, cyc, ok);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (!ok || {mem_req, mem_we, d_ready} !== 3'b110 || mem_addr !== 32'h200 || mem_wdata !== 32'h1234_5678) begin
        errors++;
        $display("FAIL write_hold_%0d: got req=%b we=%b dr=%b addr=%h wdata=%h, want 1 1 0 00000200 12345678",
                 k, mem_req, mem_we, d_ready, mem_addr, mem_wdata);
      end
      if (k == 2) begin
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_AAAA;
      end
      tick();
    end
    mem_ack = 1'b0;
    last_was_d = 1'b1;
    if (d_ready === 1'b1) pulses++;
    checks++;
    if (d_ready !== 1'b1 || mem_req !== 1'b0 || d_rdata !== d_rdata_exp) begin
      errors++;
      $display("FAIL write_resp: got dr=%b req=%b drd=%h, want 1 0 %h", d_ready, mem_req, d_rdata, d_rdata_exp);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (d_ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL write_pulses: got %0d ready pulses, want 1", pulses);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit ok;
    bit seen_ready;
    seen_ready = 1'b0;
    if_addr = 32'h0000_0055;
    if_req  = 1'b1;
    wait_mem_req(4, cyc, ok);
    #1;
    reset  = 1'b0;
    if_req = 1'b0;
    #1;
    checks++;
    if (!ok || {mem_req, mem_we, if_ready, d_ready, err, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got ok=%b req=%b addr=%h ifrd=%h drd=%h ifr=%b, want all 0",
               ok, mem_req, mem_addr, if_rdata, d_rdata, if_ready);
    end
    mem_ack = 1'b1;
    repeat (3) begin
      tick();
      if (if_ready === 1'b1 || d_ready === 1'b1) seen_ready = 1'b1;
    end
    mem_ack = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) begin
      tick();
      if (if_ready === 1'b1 || d_ready === 1'b1) seen_ready = 1'b1;
    end
    checks++;
    if (seen_ready || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_ready: got ready_seen=%b req=%b, want 0 0", seen_ready, mem_req);
    end
  endtask

  task automatic test_timeout;
    int cyc;
    bit ok;
    int hi;
    hi = 0;
    if_addr = 32'h0000_0077;
    if_req  = 1'b1;
    wait_mem_req(4, cyc, ok);
    for (int i = 0; i < 40; i++) begin
      if (mem_req !== 1'b1) break;
      hi++;
      tick();
    end
`ifdef MEM_ARB_TIMEOUT_EN
    checks++;
    if (!ok || hi != 15 || if_ready !== 1'b1 || if_rdata !== 32'hFFFF_FFFF || err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_expiry: got req_cycles=%0d ifr=%b ifrd=%h err=%b, want 15 1 ffffffff 1",
               hi, if_ready, if_rdata, err);
    end
    if_req = 1'b0;
    repeat (3) tick();
    checks++;
    if (err !== 1'b1 || if_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: got err=%b ifr=%b, want 1 0", err, if_ready);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_clear: got err=%b, want 0", err);
    end
`else
    checks++;
    if (!ok || hi != 40 || err !== 1'b0 || if_ready !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_wait: got req_cycles=%0d err=%b ifr=%b, want 40 0 0", hi, err, if_ready);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0;
    if_rdata_exp = 32'h0BAD_F00D;
    last_was_d = 1'b0;
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== if_rdata_exp || err !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_late_ack: got ifr=%b ifrd=%h err=%b, want 1 0badf00d 0", if_ready, if_rdata, err);
    end
    if_req = 1'b0;
    tick();
`endif
  endtask

  task automatic test_round_robin;
    int cyc;
    bit ok;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    if_addr = 32'h0000_00A0;
    d_addr  = 32'h0000_00D0;
    d_we    = 1'b0;
    if_req  = 1'b1;
    d_req   = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic [AW-1:0] want;
      want = (t % 2 == 0) ? 32'hA0 : 32'hD0;
      wait_mem_req(4, cyc, ok);
      checks++;
      if (!ok || mem_addr !== want) begin
        errors++;
        $display("FAIL rr_grant_%0d: got ok=%b addr=%h, want %h", t, ok, mem_addr, want);
      end
      mem_ack = 1'b1;
      mem_rdata = 32'h0 + t;
      tick();
      mem_ack = 1'b0;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    last_was_d = 1'b1;
    if_rdata_exp = 32'd2;
    d_rdata_exp  = 32'd3;
    tick();
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      int cyc;
      bit ok;
      int pat;
      int delay;
      bit win_d;
      bit exp_ifr;
      bit exp_dr;
      logic [AW-1:0] exp_addr;
      logic          exp_we;
      logic [DW-1:0] exp_wdata;
      logic [DW-1:0] rd;
      pat     = $urandom_range(1, 3);
      delay   = $urandom_range(0, 3);
      rd      = $urandom;
      if_addr = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_we    = $urandom_range(0, 1);
      if_req  = pat[0];
      d_req   = pat[1];
      if (pat == 3) win_d = ~last_was_d;
      else          win_d = (pat == 2);
      exp_addr  = win_d ? d_addr : if_addr;
      exp_we    = win_d ? d_we : 1'b0;
      exp_wdata = d_wdata;
      wait_mem_req(4, cyc, ok);
      checks++;
      if (!ok || cyc != 1 || mem_addr !== exp_addr || mem_we !== exp_we ||
          (win_d && exp_we && mem_wdata !== exp_wdata)) begin
        errors++;
        $display("FAIL rand_grant_%0d: got ok=%b cyc=%0d addr=%h we=%b wdata=%h, want cyc=1 addr=%h we=%b",
                 n, ok, cyc, mem_addr, mem_we, mem_wdata, exp_addr, exp_we);
      end
      if ($urandom_range(0, 1) == 1) begin
        if_req  = 1'b0;
        d_req   = 1'b0;
        if_addr = ~if_addr;
        d_addr  = ~d_addr;
        d_wdata = ~d_wdata;
      end
      for (int k = 0; k < delay; k++) begin
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== exp_we || {if_ready, d_ready} !== 2'b00) begin
          errors++;
          $display("FAIL rand_hold_%0d: got req=%b addr=%h we=%b ifr=%b dr=%b, want 1 %h %b 0 0",
                   n, mem_req, mem_addr, mem_we, if_ready, d_ready, exp_addr, exp_we);
        end
      end
      mem_ack = 1'b1;
      mem_rdata = rd;
      tick();
      mem_ack = 1'b0;
      last_was_d = win_d;
      if (!win_d) if_rdata_exp = rd;
      else if (!exp_we) d_rdata_exp = rd;
      exp_ifr = ~win_d;
      exp_dr  = win_d;
      checks++;
      if ({if_ready, d_ready, mem_req} !== {exp_ifr, exp_dr, 1'b0} || if_rdata !== if_rdata_exp ||
          d_rdata !== d_rdata_exp || stall !== ((if_req & ~exp_ifr) | (d_req & ~exp_dr))) begin
        errors++;
        $display("FAIL rand_resp_%0d: got ifr=%b dr=%b req=%b ifrd=%h drd=%h stall=%b, want %b %b 0 %h %h",
                 n, if_ready, d_ready, mem_req, if_rdata, d_rdata, stall, exp_ifr, exp_dr, if_rdata_exp, d_rdata_exp);
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      tick();
      checks++;
      if ({if_ready, d_ready, mem_req} !== 3'b000) begin
        errors++;
        $display("FAIL rand_idle_%0d: got ifr=%b dr=%b req=%b, want 0 0 0", n, if_ready, d_ready, mem_req);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single_read();
    test_write_delay();
    test_reset_mid();
    test_timeout();
    test_round_robin();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
